// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle RV32I main control FSM with memory handshake timeout and sticky traps
module mc_main_fsm #(
  parameter int MEM_TO_W    = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic       br_cond_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] imm_src_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_AUIPC, S_TRAP
  } state_e;
  localparam logic [MEM_TO_W-1:0] TO_LAST = MEM_TO_W'(MEM_TIMEOUT - 1);
  state_e              state_q, state_d;
  logic [MEM_TO_W-1:0] cnt_q, cnt_d;
  logic                illegal_q, illegal_d, bus_err_q, bus_err_d, waiting;
  assign imm_src_o = (op_i == 7'b0100011) ? 3'b001 :
                     (op_i == 7'b1100011) ? 3'b010 :
                     (op_i == 7'b1101111) ? 3'b011 :
                     (op_i == 7'b0110111 || op_i == 7'b0010111) ? 3'b100 : 3'b000;
  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    waiting      = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    retire_o     = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        waiting   = 1'b1;
        if (mem_ready_i) begin
          ir_write_o   = 1'b1;
          pc_write_o   = 1'b1;
          alu_src_b_o  = 2'b10;
          result_src_o = 2'b10;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXECR;
          7'b0010011: state_d = S_EXECI;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = S_JALR;
          7'b0110111: state_d = S_LUI;
          7'b0010111: state_d = S_AUIPC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = (op_i == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        waiting   = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        waiting     = 1'b1;
        retire_o    = mem_ready_i;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_op_o    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write_o  = br_cond_i;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = S_JAL;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_LUI, S_AUIPC: begin
        alu_src_a_o = (state_q == S_LUI) ? 2'b11 : 2'b01;
        alu_src_b_o = 2'b01;
        state_d     = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
    // Ready on the last allowed cycle still completes normally.
    if (waiting && !mem_ready_i && cnt_q == TO_LAST) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end
    cnt_d = (waiting && state_d == state_q) ? cnt_q + MEM_TO_W'(1) : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_BOOT;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: directed per-instruction state/control sequences, traps, timeout and async reset
module tb_mc_main_fsm;
  logic clk = 1'b0, rst_n = 1'b0, br = 1'b0, rdy = 1'b0;
  logic [6:0] op = 7'b0010011;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal, bus_err;
  logic [1:0] result_src, a_src, b_src, alu_op;
  logic [2:0] imm_src;
  logic [3:0] st;
  logic [14:0] ctl;
  int tests = 0, fails = 0;

  mc_main_fsm dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .br_cond_i(br), .mem_ready_i(rdy),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .adr_src_o(adr_src), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .reg_write_o(reg_write), .result_src_o(result_src),
    .alu_src_a_o(a_src), .alu_src_b_o(b_src), .alu_op_o(alu_op), .imm_src_o(imm_src),
    .retire_o(retire), .illegal_o(illegal), .bus_err_o(bus_err), .state_o(st)
  );

  always #5 clk = ~clk;
  assign ctl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, a_src, b_src, alu_op, retire};

  localparam logic [3:0] BOOT = 0, FETCH = 1, DEC = 2, MADR = 3, MRD = 4, MWB = 5, MWR = 6,
    EXR = 7, EXI = 8, AWB = 9, BRN = 10, JALR = 11, JAL = 12, LUI = 13, AUI = 14, TRAP = 15;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011, RI = 7'b0010011,
    BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
    BAD = 7'b1111111;
  // {req, wr, adr, ir, pc, rw, res[2], a[2], b[2], op[2], retire}
  localparam logic [14:0]
    C_0   = 15'b0_0_0_0_0_0_00_00_00_00_0,
    C_FR  = 15'b1_0_0_1_1_0_10_00_10_00_0,
    C_FW  = 15'b1_0_0_0_0_0_00_00_00_00_0,
    C_DEC = 15'b0_0_0_0_0_0_00_01_01_00_0,
    C_EXI = 15'b0_0_0_0_0_0_00_10_01_10_0,
    C_EXR = 15'b0_0_0_0_0_0_00_10_00_10_0,
    C_AWB = 15'b0_0_0_0_0_1_00_00_00_00_1,
    C_MA  = 15'b0_0_0_0_0_0_00_10_01_00_0,
    C_MR  = 15'b1_0_1_0_0_0_00_00_00_00_0,
    C_MWB = 15'b0_0_0_0_0_1_01_00_00_00_1,
    C_MW  = 15'b1_1_1_0_0_0_00_00_00_00_0,
    C_MWR = 15'b1_1_1_0_0_0_00_00_00_00_1,
    C_BR1 = 15'b0_0_0_0_1_0_00_10_00_01_1,
    C_BR0 = 15'b0_0_0_0_0_0_00_10_00_01_1,
    C_JAL = 15'b0_0_0_0_1_0_00_01_10_00_0,
    C_LUI = 15'b0_0_0_0_0_0_00_11_01_00_0;

  typedef struct packed {
    logic [6:0]  op;
    logic        rdy;
    logic        br;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [2:0]  imm;
  } row_t;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op = RI;
    rdy = 1'b1;
    repeat (2) step();
    tests++; if (st !== BOOT) begin fails++; $display("FAIL reset state got %0d exp %0d", st, BOOT); end
    tests++; if (ctl !== C_0) begin fails++; $display("FAIL reset ctl got %b exp %b", ctl, C_0); end
    tests++; if ({illegal, bus_err} !== 2'b00) begin fails++; $display("FAIL reset sticky got %b exp 00", {illegal, bus_err}); end
    tests++; if (imm_src !== 3'b000) begin fails++; $display("FAIL reset imm got %b exp 000", imm_src); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    row_t r[5] = '{
      '{RI, 1'b1, 1'b0, BOOT, C_0, 3'b000}, '{RI, 1'b1, 1'b0, FETCH, C_FR, 3'b000},
      '{RI, 1'b1, 1'b0, DEC, C_DEC, 3'b000}, '{RI, 1'b1, 1'b0, EXI, C_EXI, 3'b000},
      '{RI, 1'b1, 1'b0, AWB, C_AWB, 3'b000}};
    foreach (r[i]) begin
      op = r[i].op; rdy = r[i].rdy; br = r[i].br; #1;
      tests++; if (st !== r[i].st) begin fails++; $display("FAIL addi[%0d] state got %0d exp %0d", i, st, r[i].st); end
      tests++; if (ctl !== r[i].ctl) begin fails++; $display("FAIL addi[%0d] ctl got %b exp %b", i, ctl, r[i].ctl); end
      tests++; if (imm_src !== r[i].imm) begin fails++; $display("FAIL addi[%0d] imm got %b exp %b", i, imm_src, r[i].imm); end
      step();
    end
  endtask

  task automatic test_alu();
    row_t r[12] = '{
      '{RR, 1'b1, 1'b0, FETCH, C_FR, 3'b000}, '{RR, 1'b0, 1'b0, DEC, C_DEC, 3'b000},
      '{RR, 1'b0, 1'b0, EXR, C_EXR, 3'b000}, '{RR, 1'b0, 1'b0, AWB, C_AWB, 3'b000},
      '{LU, 1'b1, 1'b0, FETCH, C_FR, 3'b100}, '{LU, 1'b1, 1'b0, DEC, C_DEC, 3'b100},
      '{LU, 1'b1, 1'b0, LUI, C_LUI, 3'b100}, '{LU, 1'b1, 1'b0, AWB, C_AWB, 3'b100},
      '{AU, 1'b1, 1'b0, FETCH, C_FR, 3'b100}, '{AU, 1'b1, 1'b0, DEC, C_DEC, 3'b100},
      '{AU, 1'b1, 1'b0, AUI, C_DEC, 3'b100}, '{AU, 1'b1, 1'b0, AWB, C_AWB, 3'b100}};
    foreach (r[i]) begin
      op = r[i].op; rdy = r[i].rdy; br = r[i].br; #1;
      tests++; if (st !== r[i].st) begin fails++; $display("FAIL alu[%0d] state got %0d exp %0d", i, st, r[i].st); end
      tests++; if (ctl !== r[i].ctl) begin fails++; $display("FAIL alu[%0d] ctl got %b exp %b", i, ctl, r[i].ctl); end
      tests++; if (imm_src !== r[i].imm) begin fails++; $display("FAIL alu[%0d] imm got %b exp %b", i, imm_src, r[i].imm); end
      step();
    end
  endtask

  task automatic test_load_store();
    row_t r[13] = '{
      '{LD, 1'b1, 1'b0, FETCH, C_FR, 3'b000}, '{LD, 1'b1, 1'b0, DEC, C_DEC, 3'b000},
      '{LD, 1'b1, 1'b0, MADR, C_MA, 3'b000}, '{LD, 1'b0, 1'b0, MRD, C_MR, 3'b000},
      '{LD, 1'b0, 1'b0, MRD, C_MR, 3'b000}, '{LD, 1'b0, 1'b0, MRD, C_MR, 3'b000},
      '{LD, 1'b1, 1'b0, MRD, C_MR, 3'b000}, '{LD, 1'b1, 1'b0, MWB, C_MWB, 3'b000},
      '{ST, 1'b1, 1'b0, FETCH, C_FR, 3'b001}, '{ST, 1'b1, 1'b0, DEC, C_DEC, 3'b001},
      '{ST, 1'b1, 1'b0, MADR, C_MA, 3'b001}, '{ST, 1'b0, 1'b0, MWR, C_MW, 3'b001},
      '{ST, 1'b1, 1'b0, MWR, C_MWR, 3'b001}};
    foreach (r[i]) begin
      op = r[i].op; rdy = r[i].rdy; br = r[i].br; #1;
      tests++; if (st !== r[i].st) begin fails++; $display("FAIL ldst[%0d] state got %0d exp %0d", i, st, r[i].st); end
      tests++; if (ctl !== r[i].ctl) begin fails++; $display("FAIL ldst[%0d] ctl got %b exp %b", i, ctl, r[i].ctl); end
      tests++; if (imm_src !== r[i].imm) begin fails++; $display("FAIL ldst[%0d] imm got %b exp %b", i, imm_src, r[i].imm); end
      step();
    end
  endtask

  task automatic test_branch();
    row_t r[6] = '{
      '{BR, 1'b1, 1'b1, FETCH, C_FR, 3'b010}, '{BR, 1'b0, 1'b1, DEC, C_DEC, 3'b010},
      '{BR, 1'b0, 1'b1, BRN, C_BR1, 3'b010}, '{BR, 1'b1, 1'b0, FETCH, C_FR, 3'b010},
      '{BR, 1'b0, 1'b0, DEC, C_DEC, 3'b010}, '{BR, 1'b0, 1'b0, BRN, C_BR0, 3'b010}};
    foreach (r[i]) begin
      op = r[i].op; rdy = r[i].rdy; br = r[i].br; #1;
      tests++; if (st !== r[i].st) begin fails++; $display("FAIL branch[%0d] state got %0d exp %0d", i, st, r[i].st); end
      tests++; if (ctl !== r[i].ctl) begin fails++; $display("FAIL branch[%0d] ctl got %b exp %b", i, ctl, r[i].ctl); end
      tests++; if (imm_src !== r[i].imm) begin fails++; $display("FAIL branch[%0d] imm got %b exp %b", i, imm_src, r[i].imm); end
      step();
    end
  endtask

  task automatic test_jumps();
    row_t r[9] = '{
      '{JR, 1'b1, 1'b0, FETCH, C_FR, 3'b000}, '{JR, 1'b1, 1'b0, DEC, C_DEC, 3'b000},
      '{JR, 1'b1, 1'b0, JALR, C_MA, 3'b000}, '{JR, 1'b1, 1'b0, JAL, C_JAL, 3'b000},
      '{JR, 1'b1, 1'b0, AWB, C_AWB, 3'b000}, '{JL, 1'b1, 1'b0, FETCH, C_FR, 3'b011},
      '{JL, 1'b1, 1'b0, DEC, C_DEC, 3'b011}, '{JL, 1'b1, 1'b0, JAL, C_JAL, 3'b011},
      '{JL, 1'b1, 1'b0, AWB, C_AWB, 3'b011}};
    foreach (r[i]) begin
      op = r[i].op; rdy = r[i].rdy; br = r[i].br; #1;
      tests++; if (st !== r[i].st) begin fails++; $display("FAIL jump[%0d] state got %0d exp %0d", i, st, r[i].st); end
      tests++; if (ctl !== r[i].ctl) begin fails++; $display("FAIL jump[%0d] ctl got %b exp %b", i, ctl, r[i].ctl); end
      tests++; if (imm_src !== r[i].imm) begin fails++; $display("FAIL jump[%0d] imm got %b exp %b", i, imm_src, r[i].imm); end
      step();
    end
  endtask

  task automatic test_illegal();
    row_t r[5] = '{
      '{BAD, 1'b1, 1'b0, FETCH, C_FR, 3'b000}, '{BAD, 1'b1, 1'b0, DEC, C_DEC, 3'b000},
      '{BAD, 1'b1, 1'b0, TRAP, C_0, 3'b000}, '{RI, 1'b1, 1'b0, TRAP, C_0, 3'b000},
      '{LD, 1'b1, 1'b0, TRAP, C_0, 3'b000}};
    foreach (r[i]) begin
      op = r[i].op; rdy = r[i].rdy; br = r[i].br; #1;
      tests++; if (st !== r[i].st) begin fails++; $display("FAIL illegal[%0d] state got %0d exp %0d", i, st, r[i].st); end
      tests++; if (ctl !== r[i].ctl) begin fails++; $display("FAIL illegal[%0d] ctl got %b exp %b", i, ctl, r[i].ctl); end
      tests++; if (imm_src !== r[i].imm) begin fails++; $display("FAIL illegal[%0d] imm got %b exp %b", i, imm_src, r[i].imm); end
      step();
    end
    tests++; if ({illegal, bus_err} !== 2'b10) begin fails++; $display("FAIL illegal sticky got %b exp 10", {illegal, bus_err}); end
    // Asynchronous reset between clock edges must act without waiting for clk.
    #2 rst_n = 1'b0;
    #1;
    tests++; if (st !== BOOT) begin fails++; $display("FAIL async_reset state got %0d exp %0d", st, BOOT); end
    tests++; if ({illegal, mem_req} !== 2'b00) begin fails++; $display("FAIL async_reset ill/req got %b exp 00", {illegal, mem_req}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    op = RI;
    rdy = 1'b0;
    step();
    for (int k = 1; k <= 200; k++) begin
      #1;
      tests++; if ({st, mem_req, bus_err} !== {FETCH, 1'b1, 1'b0}) begin fails++; $display("FAIL timeout_wait[%0d] st/req/err got %0d/%b/%b exp 1/1/0", k, st, mem_req, bus_err); end
      step();
    end
    tests++; if (st !== TRAP) begin fails++; $display("FAIL timeout state got %0d exp %0d", st, TRAP); end
    tests++; if ({bus_err, illegal, mem_req} !== 3'b100) begin fails++; $display("FAIL timeout err/ill/req got %b exp 100", {bus_err, illegal, mem_req}); end
    rdy = 1'b1;
    step();
    tests++; if ({st, mem_req, bus_err} !== {TRAP, 1'b0, 1'b1}) begin fails++; $display("FAIL timeout_hold st/req/err got %0d/%b/%b exp 15/0/1", st, mem_req, bus_err); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rdy = 1'b0;
    step();
    for (int k = 1; k < 200; k++) step();
    rdy = 1'b1;
    #1;
    tests++; if ({st, ir_write} !== {FETCH, 1'b1}) begin fails++; $display("FAIL limit_ready st/ir got %0d/%b exp 1/1", st, ir_write); end
    step();
    tests++; if ({st, bus_err} !== {DEC, 1'b0}) begin fails++; $display("FAIL limit_ready next st/err got %0d/%b exp 2/0", st, bus_err); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_addi();
    test_alu();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
